// File: rtl/rect_fill.sv
// Rectangle-fill engine driving VRAM port A: clips a command rectangle to the
// framebuffer and writes one pixel per clock in row-major order.
`timescale 1ns/1ps
module rect_fill #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [11:0]       cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] write_addr,
  output logic [11:0]       write_data,
  output logic              write_en
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FILL,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [9:0]        FB_W10   = 10'(FB_W);
  localparam logic [9:0]        FB_H10   = 10'(FB_H);

  state_t state_q, state_d;

  logic [8:0]        x_q, w_q;
  logic [7:0]        y_q, h_q;
  logic [11:0]       color_q;

  logic [8:0]        wc_q, col_q;
  logic [7:0]        hc_q, row_q;
  logic [ADDR_W-1:0] row_base_q;

  logic [9:0]        avail_w, avail_h, wc_calc, hc_calc;
  logic [ADDR_W-1:0] base_calc;
  logic              setup_empty, last_col, last_row;

  // NOTE: the captured command is only read after a handshake loads it, so
  // these registers carry no reset; control state below is reset.
  always_ff @(posedge write_clk) begin
    if (cmd_valid && cmd_ready) begin
      x_q     <= cmd_x;
      y_q     <= cmd_y;
      w_q     <= cmd_w;
      h_q     <= cmd_h;
      color_q <= cmd_color;
    end
  end

  // Clipping is done at 10 bits so FB_W-x and FB_H-y never wrap.
  always_comb begin
    avail_w = FB_W10 - {1'b0, x_q};
    avail_h = FB_H10 - {2'b00, y_q};
    wc_calc = 10'd0;
    hc_calc = 10'd0;
    if ({1'b0, x_q} < FB_W10)
      wc_calc = ({1'b0, w_q} < avail_w) ? {1'b0, w_q} : avail_w;
    if ({2'b00, y_q} < FB_H10)
      hc_calc = ({2'b00, h_q} < avail_h) ? {2'b00, h_q} : avail_h;
    setup_empty = (wc_calc == 10'd0) || (hc_calc == 10'd0);
  end

  generate
    if (FB_W == 320) begin : g_base_shift
      // 320*y = 256*y + 64*y, so the row base needs no multiplier.
      assign base_calc = ADDR_W'({y_q, 8'b0}) + ADDR_W'({y_q, 6'b0}) + ADDR_W'(x_q);
    end else begin : g_base_mult
      assign base_calc = ADDR_W'(y_q) * ROW_STEP + ADDR_W'(x_q);
    end
  endgenerate

  assign last_col = (col_q == wc_q - 9'd1);
  assign last_row = (row_q == hc_q - 8'd1);

  always_ff @(posedge write_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid && cmd_ready) state_d = S_SETUP;
      S_SETUP: state_d = setup_empty ? S_DONE : S_FILL;
      S_FILL:  if (last_col && last_row) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      wc_q       <= '0;
      hc_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      cmd_ready <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      write_en  <= (state_d == S_FILL);

      case (state_q)
        S_SETUP: begin
          wc_q       <= wc_calc[8:0];
          hc_q       <= hc_calc[7:0];
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= base_calc;
          if (!setup_empty) begin
            write_addr <= base_calc;
            write_data <= color_q;
          end
        end
        S_FILL: begin
          if (!last_col) begin
            col_q      <= col_q + 9'd1;
            write_addr <= row_base_q + ADDR_W'(col_q) + ONE_A;
          end else if (!last_row) begin
            col_q      <= '0;
            row_q      <= row_q + 8'd1;
            row_base_q <= row_base_q + ROW_STEP;
            write_addr <= row_base_q + ROW_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: directed cases plus random commands,
// each compared cycle by cycle against a pixel-list model of the fill.
`timescale 1ns/1ps
module tb_rect_fill;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int ADDR_W = 17;

  logic              write_clk = 1'b0;
  logic              reset     = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [8:0]        cmd_x     = '0;
  logic [7:0]        cmd_y     = '0;
  logic [8:0]        cmd_w     = '0;
  logic [7:0]        cmd_h     = '0;
  logic [11:0]       cmd_color = '0;
  logic              busy, done, write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [11:0]       write_data;

  int n_cmp  = 0;
  int n_fail = 0;

  rect_fill #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .write_clk  (write_clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .busy       (busy),
    .done       (done),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_en   (write_en)
  );

  always #5 write_clk = ~write_clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel addresses: every in-frame pixel of the rectangle, row-major.
  task automatic model_pixels(input int x, input int y, input int w, input int h,
                              output int q[$]);
    q = {};
    for (int yy = y; yy < y + h; yy++)
      for (int xx = x; xx < x + w; xx++)
        if (xx < FB_W && yy < FB_H) q.push_back(FB_W * yy + xx);
  endtask

  // Issue one command and check every cycle until cmd_ready returns.
  // abort_after > 0 pulses reset after that many writes instead.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input logic [11:0] color, input int abort_after);
    int exp_q[$];
    int n;
    int wait_cnt;
    model_pixels(x, y, w, h, exp_q);
    n = exp_q.size();

    @(negedge write_clk);
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 10) begin
      @(negedge write_clk);
      wait_cnt++;
    end
    check("ready_before_cmd", cmd_ready, 1'b1);

    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = color;
    cmd_valid = 1'b1;
    @(negedge write_clk);
    check("setup_busy", busy, 1'b1);
    check("setup_ready", cmd_ready, 1'b0);
    check("setup_we", write_en, 1'b0);
    check("setup_done", done, 1'b0);

    for (int k = 1; k <= n + 2; k++) begin
      // Scribble over the command inputs while the engine is not ready.
      if (k <= n) begin
        cmd_valid = 1'b1;
        cmd_x = 9'($urandom); cmd_y = 8'($urandom); cmd_w = 9'($urandom);
        cmd_h = 8'($urandom); cmd_color = 12'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge write_clk);
      check("we", write_en, (k <= n));
      check("done", done, (k == n + 1));
      check("ready", cmd_ready, (k == n + 2));
      check("busy", busy, (k <= n + 1));
      if (k <= n) begin
        check("addr", write_addr, exp_q[k-1]);
        check("data", write_data, color);
      end
      if (abort_after > 0 && k == abort_after) begin
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge write_clk);
        reset = 1'b0;
        check("abort_we", write_en, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", cmd_ready, 1'b1);
        @(negedge write_clk);
        check("abort_done_after", done, 1'b0);
        check("abort_we_after", write_en, 1'b0);
        return;
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a command offered; it must not be taken.
    cmd_valid = 1'b1;
    cmd_x = 9'd1; cmd_y = 8'd1; cmd_w = 9'd4; cmd_h = 8'd4; cmd_color = 12'hABC;
    repeat (2) @(posedge write_clk);
    @(negedge write_clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_we", write_en, 1'b0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    check("rst_done", done, 1'b0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    repeat (2) begin
      @(negedge write_clk);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_we", write_en, 1'b0);
    end

    // Directed cases.
    run_cmd(10, 5, 3, 2, 12'hF00, 0);
    run_cmd(318, 238, 5, 5, 12'h00F, 0);
    run_cmd(20, 30, 0, 7, 12'h123, 0);
    run_cmd(400, 10, 10, 10, 12'h456, 0);
    run_cmd(5, 250, 10, 10, 12'h789, 0);
    run_cmd(0, 0, 320, 240, 12'h0F0, 0);

    // Reset mid-fill, then a fresh command straight after.
    run_cmd(0, 0, 320, 240, 12'h0F0, 100);
    run_cmd(10, 5, 3, 2, 12'hF00, 0);

    // Random commands biased toward the frame edges.
    for (int i = 0; i < 14; i++) begin
      run_cmd($urandom_range(0, 340), $urandom_range(0, 250),
              $urandom_range(0, 24), $urandom_range(0, 16),
              12'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
